// File: rtl/bpu_upd_sched_pkg.sv
// Shared types for the branch-predictor update scheduler: the update payload,
// the scheduler FSM states and the default queue depth.
package bpu_upd_sched_pkg;

  localparam int BPU_UPDQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        flush;
    logic        btb_update;
    logic        bht_update;
    logic        lpht_update;
  } bpu_update_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_upd_state_t;

  // Only updates that touch at least one table are worth a write slot.
  function automatic logic upd_useful(input bpu_update_t u);
    return u.btb_update | u.bht_update | u.lpht_update;
  endfunction

endpackage

// File: rtl/bpu_upd_sched_if.sv
// Bundle of the two execute-stage feedback channels and the shared table
// write port seen by the update scheduler.
interface bpu_upd_sched_if #(
  parameter int IDX_W = 10
);
  import bpu_upd_sched_pkg::*;

  logic              upd0_valid_i;
  bpu_update_t       upd0_i;
  logic              upd1_valid_i;
  bpu_update_t       upd1_i;
  logic              stall_o;
  logic              tbl_ready_i;
  logic              tbl_we_o;
  bpu_update_t       tbl_upd_o;
  logic              tbl_init_o;
  logic [IDX_W-1:0]  tbl_init_idx_o;
  logic              init_done_o;

  modport master (
    output upd0_valid_i, upd0_i, upd1_valid_i, upd1_i, tbl_ready_i,
    input  stall_o, tbl_we_o, tbl_upd_o, tbl_init_o, tbl_init_idx_o, init_done_o
  );

  modport slave (
    input  upd0_valid_i, upd0_i, upd1_valid_i, upd1_i, tbl_ready_i,
    output stall_o, tbl_we_o, tbl_upd_o, tbl_init_o, tbl_init_idx_o, init_done_o
  );

endinterface

// File: rtl/bpu_upd_fifo.sv
// Circular buffer with two write ports and one read port. Port 0 holds the
// older entry; when both write, port 1 lands in the slot after port 0.
module bpu_upd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0],
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr0_i,
  input  T                 wr0_data_i,
  input  logic             wr1_i,
  input  T                 wr1_data_i,
  input  logic             rd_i,
  output T                 rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] free_o
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] slot1;
  logic [CNT_W-1:0] n_wr;

  assign slot1 = tail_q + PTR_W'(wr0_i);
  assign n_wr  = CNT_W'(wr0_i) + CNT_W'(wr1_i);

  // Entries are cleared on reset so the read port shows all-zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr0_i) mem[tail_q] <= wr0_data_i;
      if (wr1_i) mem[slot1] <= wr1_data_i;
      tail_q  <= tail_q + PTR_W'(n_wr);
      head_q  <= head_q + PTR_W'(rd_i);
      count_q <= count_q + n_wr - CNT_W'(rd_i);
    end
  end

  assign rd_data_o = mem[head_q];
  assign count_o   = count_q;
  assign free_o    = CNT_W'(DEPTH) - count_q;

endmodule

// File: rtl/bpu_upd_sched.sv
// Branch-predictor table write scheduler: zero-fills the tables after reset,
// then queues useful execute-stage updates in program order and drains them.
module bpu_upd_sched
  import bpu_upd_sched_pkg::*;
#(
  parameter int DEPTH = BPU_UPDQ_DEPTH,
  parameter int IDX_W = 10
) (
  input logic            clk,
  input logic            rst_n,
  bpu_upd_sched_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  bpu_upd_state_t   state_q;
  bpu_upd_state_t   state_d;
  logic [IDX_W-1:0] sweep_q;
  logic [IDX_W-1:0] sweep_d;
  logic             init_wr;
  logic             init_done;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic             stall;
  logic             kill1;
  logic             enq0;
  logic             enq1;
  logic             deq;
  bpu_update_t      head_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // The sweep only advances on cycles where fetch has released the port.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    init_wr   = 1'b0;
    init_done = 1'b0;
    case (state_q)
      INIT: begin
        init_wr = bus.tbl_ready_i;
        if (bus.tbl_ready_i) begin
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == '1) state_d = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Stall uses the registered occupancy so it never depends on this cycle's drain.
  assign stall = ~init_done | (free < CNT_W'(2));
  assign kill1 = bus.upd0_valid_i & bus.upd0_i.flush;
  assign enq0  = bus.upd0_valid_i & ~stall & upd_useful(bus.upd0_i);
  assign enq1  = bus.upd1_valid_i & ~stall & ~kill1 & upd_useful(bus.upd1_i);
  assign deq   = (count != '0) & bus.tbl_ready_i;

  bpu_upd_fifo #(
    .DEPTH (DEPTH),
    .T     (bpu_update_t)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr0_i      (enq0),
    .wr0_data_i (bus.upd0_i),
    .wr1_i      (enq1),
    .wr1_data_i (bus.upd1_i),
    .rd_i       (deq),
    .rd_data_o  (head_upd),
    .count_o    (count),
    .free_o     (free)
  );

  assign bus.stall_o        = stall;
  assign bus.tbl_we_o       = deq;
  assign bus.tbl_upd_o      = head_upd;
  assign bus.tbl_init_o     = init_wr;
  assign bus.tbl_init_idx_o = sweep_q;
  assign bus.init_done_o    = init_done;

endmodule

// File: doc/bpu_upd_sched.md
# bpu_upd_sched

Sequences branch-predictor table writes. Collects per-pipe `bpu_update_t` feedback from the two execute-stage feedback units. Queues the updates in program order in a small multi-write buffer and drains them one per cycle into the single write port shared by BTB/BHT/PHT. After reset it owns the write port for a zero-fill sweep of the untracked tables. The front-end redirect (`flush`, `br_target`) does not pass through this block; only table writes do.

## Interface
- `DEPTH`, 4 — queue entries; power of two, ≥ 2.
- `IDX_W`, 10 — table index width; the init sweep covers 2^IDX_W entries.
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `upd0_valid_i` in 1 — pipe 0 (older instruction) update valid.
- `upd0_i` in `bpu_update_t` — pipe 0 update payload.
- `upd1_valid_i` in 1 — pipe 1 (younger instruction) update valid.
- `upd1_i` in `bpu_update_t` — pipe 1 update payload.
- `stall_o` out 1 — back-pressure to both pipes.
- `tbl_ready_i` in 1 — table port accepts a write this cycle (low while fetch owns the port).
- `tbl_we_o` out 1 — write strobe for a queued update.
- `tbl_upd_o` out `bpu_update_t` — the update being written, valid with `tbl_we_o`.
- `tbl_init_o` out 1 — zero-fill write strobe.
- `tbl_init_idx_o` out `IDX_W` — index being zero-filled.
- `init_done_o` out 1 — init sweep complete.

## Operation
- FSM states: `INIT`, `RUN`. Reset enters `INIT` with sweep counter 0.
- `INIT`:
  - `tbl_init_o = tbl_ready_i`; `tbl_init_idx_o` = counter.
  - Counter increments only when `tbl_ready_i` is high.
  - On the accepted write of index 2^IDX_W−1, go to `RUN`; the counter wraps to 0 and is unused after that.
  - Enqueue is blocked (`stall_o = 1`).
- `RUN`, filter:
  - An update is "useful" iff `btb_update | bht_update | lpht_update`.
  - Only useful updates are enqueued.
- `RUN`, flush kill:
  - If `upd0_valid_i & upd0_i.flush`, the pipe 1 update is discarded that cycle as wrong-path.
  - A pipe 1 flush never affects pipe 0.
- `RUN`, enqueue order:
  - Pipe 0 entry is written before pipe 1.
  - 0, 1 or 2 entries are written per cycle.
  - Tail advances by the number written, modulo `DEPTH`.
- `RUN`, dequeue:
  - `tbl_we_o = (count != 0) & tbl_ready_i`.
  - `tbl_upd_o` = head entry, driven every cycle regardless of strobe.
  - Head advances on `tbl_we_o`.
- `stall_o = ~init_done_o | (DEPTH − count < 2)`.
  - Computed from registered count only; same-cycle dequeue is not credited.
- Producers must not assert a valid while `stall_o` is high. Any such valid is ignored; no entry is written.
- Simultaneous enqueue and dequeue are legal: `count_next = count + n_enq − deq`.
  - Count width is clog2(DEPTH+1).
  - Pointer width is clog2(DEPTH) and wraps naturally.
- CSR flush has no effect here: queued updates belong to committed instructions and always drain.
- Entries are never reordered or merged.

## Timing
- Reset values:
  - state `INIT`, count 0, head/tail 0;
  - `stall_o` 1, `tbl_we_o` 0, `init_done_o` 0;
  - `tbl_init_o` follows `tbl_ready_i`; `tbl_init_idx_o` 0;
  - `tbl_upd_o` all-zero.
- Init lasts exactly 2^IDX_W cycles with `tbl_ready_i` held high. `init_done_o` rises the cycle after the last init write.
- Enqueue-to-write latency is a minimum of 1 cycle. There is no same-cycle bypass from input to `tbl_we_o`.
- Sustained throughput is one table write per cycle.
- Reset asserted mid-sweep or mid-drain clears all state; the sweep restarts at index 0 and queued updates are lost.

## Structure
- Uses the existing `bpu_update_t` from `bpu.svh`.
- Add to `bpu.svh`: `BPU_UPDQ_DEPTH` (default 4) and the `bpu_upd_state_t` enum {`INIT`, `RUN`}.
- One sub-module, `bpu_upd_fifo`: 2-write / 1-read circular buffer with count.
  - Parameterised by `DEPTH` and entry type.
  - Exposes `free_o` (free-entry count) for the `stall_o` computation.
- FSM, filter, kill logic and sweep counter live in `bpu_upd_sched`.

## Test plan
- Reset release, IDX_W=4, `tbl_ready_i`=1:
  - `tbl_init_idx_o` steps 0..15 over 16 cycles with `tbl_init_o`=1;
  - `init_done_o`=1 and `stall_o`=0 in cycle 17.
- Init with `tbl_ready_i` toggling every other cycle:
  - sweep takes 32 cycles;
  - no index skipped or repeated.
- Single update, `upd0_i.pc`=0x1000, `bht_update`=1, valid one cycle:
  - next cycle `tbl_we_o`=1, `tbl_upd_o.pc`=0x1000;
  - count returns to 0.
- Both pipes valid, pc 0x10 (pipe 0) and 0x11 (pipe 1), `tbl_ready_i`=0 for 3 cycles then 1:
  - writes emerge 0x10 then 0x11;
  - `stall_o` rises once count reaches 3 (DEPTH=4).
- `upd0_i.flush`=1 together with a valid useful `upd1_i`:
  - only the pipe 0 entry is enqueued; count increments by 1.
- Update with all three update bits 0: nothing enqueued.
- Update arriving while `stall_o`=1: ignored; count unchanged.
- Reset pulse at init index 7:
  - sweep restarts at index 0;
  - all outputs return to their reset values.
